// File: rtl/cbp_adder_pipe_if.sv
// Handshake/data bundle for cbp_adder_pipe: operand side (in_*) and result side (out_*).
// out_ovf exists only when CBP_OVERFLOW_EN is defined.
interface cbp_adder_pipe_if #(
   parameter int NUM_BITS = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [NUM_BITS-1:0] in_a;
   logic [NUM_BITS-1:0] in_b;
   logic                in_cin;
   logic                in_sub;
   logic                out_valid;
   logic                out_ready;
   logic [NUM_BITS-1:0] out_sum;
   logic                out_cout;
`ifdef CBP_OVERFLOW_EN
   logic                out_ovf;
`endif

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
`ifdef CBP_OVERFLOW_EN
      , input out_ovf
`endif
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout
`ifdef CBP_OVERFLOW_EN
      , output out_ovf
`endif
   );
endinterface

// File: rtl/cbp_adder_pipe.sv
// Pipelined carry-bypass adder/subtractor: one W-bit block per stage, valid/ready on both sides.
// Optional signed-overflow output is built when CBP_OVERFLOW_EN is defined.
module cbp_adder_pipe #(
   parameter int NUM_BITS   = 32,
   parameter int NUM_STAGES = 4
) (
   input logic             clk,
   input logic             rst_n,
   cbp_adder_pipe_if.slave bus
);
   localparam int W = NUM_BITS / NUM_STAGES;

   generate
      if ((NUM_STAGES < 1) || ((NUM_BITS % NUM_STAGES) != 0)) begin : g_bad_cfg
         $error("cbp_adder_pipe: NUM_BITS must be a multiple of NUM_STAGES");
      end
   endgenerate

   // Rank 0 holds captured operands; rank k+1 holds the op after block k has been evaluated.
   logic                valid_q [0:NUM_STAGES];
   logic                valid_d [0:NUM_STAGES];
   logic                c_q     [0:NUM_STAGES];
   logic                c_d     [0:NUM_STAGES];
   logic [NUM_BITS-1:0] sum_q   [0:NUM_STAGES];
   logic [NUM_BITS-1:0] sum_d   [0:NUM_STAGES];
   logic [NUM_BITS-1:0] a_q     [0:NUM_STAGES-1];
   logic [NUM_BITS-1:0] a_d     [0:NUM_STAGES-1];
   logic [NUM_BITS-1:0] b_q     [0:NUM_STAGES-1];
   logic [NUM_BITS-1:0] b_d     [0:NUM_STAGES-1];
   logic                sub_q   [0:NUM_STAGES-1];
   logic                sub_d   [0:NUM_STAGES-1];
   logic [W:0]          blk_s   [0:NUM_STAGES-1];
   logic                adv_s;
`ifdef CBP_OVERFLOW_EN
   logic                ovf_q;
   logic                ovf_d;
`endif

   // Ripple inside the block; carry-out bypasses to the block carry-in when every bit propagates.
   function automatic logic [W:0] blk_add(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         cin);
      logic [W:0]   c;
      logic [W-1:0] s;
      logic         p;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
      end
      p = &(a ^ b);
      return {(p ? cin : c[W]), s};
   endfunction

   assign adv_s         = !valid_q[NUM_STAGES] || bus.out_ready;
   assign bus.in_ready  = adv_s;
   assign bus.out_valid = valid_q[NUM_STAGES];
   assign bus.out_sum   = sum_q[NUM_STAGES];
   assign bus.out_cout  = c_q[NUM_STAGES];
`ifdef CBP_OVERFLOW_EN
   assign bus.out_ovf   = ovf_q;
`endif

   // Evaluate block k from the operands and carry held in rank k.
   always_comb begin
      for (int k = 0; k < NUM_STAGES; k++) begin
         blk_s[k] = blk_add(a_q[k][k*W +: W], b_q[k][k*W +: W], c_q[k]);
      end
   end

   // Next state: every rank shifts on advance, everything holds on stall.
   always_comb begin
      for (int k = 0; k <= NUM_STAGES; k++) begin
         valid_d[k] = valid_q[k];
         c_d[k]     = c_q[k];
         sum_d[k]   = sum_q[k];
      end
      for (int k = 0; k < NUM_STAGES; k++) begin
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sub_d[k] = sub_q[k];
      end
`ifdef CBP_OVERFLOW_EN
      ovf_d = ovf_q;
`endif
      if (adv_s) begin
         valid_d[0] = bus.in_valid;
         a_d[0]     = bus.in_a;
         sub_d[0]   = bus.in_sub;
         sum_d[0]   = {NUM_BITS{1'b0}};
         if (bus.in_sub) begin
            b_d[0] = ~bus.in_b;
            c_d[0] = 1'b1;
         end else begin
            b_d[0] = bus.in_b;
            c_d[0] = bus.in_cin;
         end
         for (int k = 0; k < NUM_STAGES; k++) begin
            valid_d[k+1]             = valid_q[k];
            c_d[k+1]                 = blk_s[k][W];
            sum_d[k+1]               = sum_q[k];
            sum_d[k+1][k*W +: W]     = blk_s[k][W-1:0];
         end
         for (int k = 0; k < NUM_STAGES - 1; k++) begin
            a_d[k+1]   = a_q[k];
            b_d[k+1]   = b_q[k];
            sub_d[k+1] = sub_q[k];
         end
`ifdef CBP_OVERFLOW_EN
         // Carry into the MSB recovered as a^b^s at that bit.
         ovf_d = a_q[NUM_STAGES-1][NUM_BITS-1] ^ b_q[NUM_STAGES-1][NUM_BITS-1]
               ^ blk_s[NUM_STAGES-1][W-1] ^ blk_s[NUM_STAGES-1][W];
`endif
      end else begin
         valid_d[0] = valid_q[0];
      end
   end

   // Rank registers with synchronous active-low clear of valid and data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k <= NUM_STAGES; k++) begin
            valid_q[k] <= 1'b0;
            c_q[k]     <= 1'b0;
            sum_q[k]   <= {NUM_BITS{1'b0}};
         end
         for (int k = 0; k < NUM_STAGES; k++) begin
            a_q[k]   <= {NUM_BITS{1'b0}};
            b_q[k]   <= {NUM_BITS{1'b0}};
            sub_q[k] <= 1'b0;
         end
`ifdef CBP_OVERFLOW_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         for (int k = 0; k <= NUM_STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            c_q[k]     <= c_d[k];
            sum_q[k]   <= sum_d[k];
         end
         for (int k = 0; k < NUM_STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sub_q[k] <= sub_d[k];
         end
`ifdef CBP_OVERFLOW_EN
         ovf_q <= ovf_d;
`endif
      end
   end
endmodule

// File: tb/tb_cbp_adder_pipe.sv
// Scoreboard bench for cbp_adder_pipe (32 bits, 4 stages) with hand-computed vectors.
// Overflow checks are included when CBP_OVERFLOW_EN is defined.
module tb_cbp_adder_pipe;
   localparam int NB = 32;
   localparam int NS = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cbp_adder_pipe_if #(.NUM_BITS(NB)) bus_if ();

   cbp_adder_pipe #(.NUM_BITS(NB), .NUM_STAGES(NS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NB-1:0] a;
      logic [NB-1:0] b;
      logic          cin;
      logic          sub;
      logic [NB-1:0] s;
      logic          co;
      logic          ov;
   } vec_t;

   typedef struct {
      logic [NB-1:0] s;
      logic          co;
      logic          ov;
      int            acc;
      bit            lat;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_xfer   = 0;
   int   base_x;
   bit   lat_chk  = 1'b1;

   function automatic vec_t mk(input logic [NB-1:0] a, input logic [NB-1:0] b,
                               input logic cin, input logic sub,
                               input logic [NB-1:0] s, input logic co, input logic ov);
      vec_t v;
      v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.co = co; v.ov = ov;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic send(input vec_t v);
      int   budget;
      exp_t e;
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = v.a;
      bus_if.in_b     = v.b;
      bus_if.in_cin   = v.cin;
      bus_if.in_sub   = v.sub;
      budget = 0;
      @(negedge clk);
      while (!bus_if.in_ready && budget < 50) begin
         budget++;
         @(negedge clk);
      end
      if (!bus_if.in_ready) begin
         check("in_ready_timeout", {63'd0, bus_if.in_ready}, 64'd1);
         bus_if.in_valid = 1'b0;
      end else begin
         e.s = v.s; e.co = v.co; e.ov = v.ov; e.acc = cyc + 1; e.lat = lat_chk;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      bus_if.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 100) begin
         budget++;
         @(posedge clk);
      end
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Edge counter used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares each transferred result against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
         n_xfer++;
         if (exp_q.size() == 0) begin
            check("unexpected_result", {63'd0, bus_if.out_valid}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_sum", {32'd0, bus_if.out_sum}, {32'd0, mon_e.s});
            check("out_cout", {63'd0, bus_if.out_cout}, {63'd0, mon_e.co});
`ifdef CBP_OVERFLOW_EN
            check("out_ovf", {63'd0, bus_if.out_ovf}, {63'd0, mon_e.ov});
`endif
            if (mon_e.lat) begin
               check("latency", 64'(cyc - mon_e.acc), 64'(NS));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.in_valid  = 1'b0;
      bus_if.in_a      = '0;
      bus_if.in_b      = '0;
      bus_if.in_cin    = 1'b0;
      bus_if.in_sub    = 1'b0;
      bus_if.out_ready = 1'b1;

      vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0));
      vecs.push_back(mk(32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0));
      vecs.push_back(mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1));
      vecs.push_back(mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1));
      vecs.push_back(mk(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0));
      vecs.push_back(mk(32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0));
      vecs.push_back(mk(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0));
      vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1));
      vecs.push_back(mk(32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEF0, 1'b0, 1'b0));
      vecs.push_back(mk(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'h55555555, 32'h55555555, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b0, 1'b1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
      check("rst_out_sum", {32'd0, bus_if.out_sum}, 64'd0);
      check("rst_out_cout", {63'd0, bus_if.out_cout}, 64'd0);
      check("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
`ifdef CBP_OVERFLOW_EN
      check("rst_out_ovf", {63'd0, bus_if.out_ovf}, 64'd0);
`endif
      rst_n = 1'b1;

      // Isolated ops separated by bubbles: bypass, subtract, overflow corners
      for (int i = 0; i < 6; i++) begin
         send(vecs[i]);
         idle(2);
      end
      drain();

      // Back-to-back stream
      for (int i = 6; i < 14; i++) send(vecs[i]);
      idle(1);
      drain();

      // Backpressure: fill all ranks, stall three cycles, then release
      lat_chk = 1'b0;
      bus_if.out_ready = 1'b0;
      for (int i = 6; i < 11; i++) send(vecs[i]);
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = vecs[11].a;
      bus_if.in_b     = vecs[11].b;
      bus_if.in_cin   = vecs[11].cin;
      bus_if.in_sub   = vecs[11].sub;
      for (int j = 0; j < 3; j++) begin
         check("stall_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
         check("stall_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
         check("stall_out_sum", {32'd0, bus_if.out_sum}, {32'd0, vecs[6].s});
         check("stall_out_cout", {63'd0, bus_if.out_cout}, {63'd0, vecs[6].co});
         @(posedge clk);
         #1;
      end
      bus_if.out_ready = 1'b1;
      base_x = n_xfer;
      send(vecs[11]);
      idle(4);
      check("release_burst", 64'(n_xfer - base_x), 64'd5);
      drain();
      lat_chk = 1'b1;

      // Reset with three ops in flight
      for (int i = 0; i < 3; i++) send(vecs[i]);
      bus_if.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      check("midrst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
      check("midrst_out_sum", {32'd0, bus_if.out_sum}, 64'd0);
      check("midrst_out_cout", {63'd0, bus_if.out_cout}, 64'd0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("midrst_no_stale", {63'd0, bus_if.out_valid}, 64'd0);
      end

      // Recovery after reset
      @(posedge clk);
      #1;
      send(vecs[3]);
      idle(1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
